// File: rtl/cic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cic_pkg : shared CIC decimator constants (integrator + comb)     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cic_pkg;
    localparam int IW         = 8;
    localparam int DECIM      = 8;
    localparam int STAGES     = 3;
    localparam int LOG2_DECIM = $clog2(DECIM);
    // Bit growth of a STAGES-deep CIC with unit differential delay
    localparam int OW         = IW + STAGES * LOG2_DECIM;
endpackage
`default_nettype wire

// File: rtl/cic_integ.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cic_integ : wrapping signed accumulator with enable              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cic_integ #(
    parameter int W = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] acc
);
    // Modulo-2^W wrap is intentional: the comb stage undoes it exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + din;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cic_integ_decim.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cic_integ_decim : 3-stage CIC integrator chain with decimator    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cic_integ_decim #(
    parameter int IW    = cic_pkg::IW,
    parameter int OW    = cic_pkg::OW,
    parameter int DECIM = cic_pkg::DECIM
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 DV,
    input  logic signed [IW-1:0] Xin,
    output logic signed [OW-1:0] Yout,
    output logic                 ND
);
    import cic_pkg::*;

    localparam int CW = $clog2(DECIM);

    logic signed [OW-1:0] din [STAGES];
    logic signed [OW-1:0] acc [STAGES];
    logic signed [OW-1:0] y_next;
    logic [CW-1:0]        cnt;
    logic                 cnt_last;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            if (s == 0) begin : g_first
                assign din[s] = {{(OW-IW){Xin[IW-1]}}, Xin};
            end else begin : g_chain
                assign din[s] = acc[s-1];
            end
            cic_integ #(.W(OW)) u_integ (
                .clk (clk),
                .rst (rst),
                .en  (DV),
                .din (din[s]),
                .acc (acc[s])
            );
        end
    endgenerate

    // Value the last integrator takes on this edge, so Yout is not a sample late
    assign y_next   = acc[STAGES-1] + acc[STAGES-2];
    assign cnt_last = (cnt == CW'(DECIM-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            Yout <= '0;
            ND   <= 1'b0;
        end else begin
            ND <= DV && cnt_last;
            if (DV) begin
                cnt <= cnt_last ? '0 : cnt + CW'(1);
                if (cnt_last) begin
                    Yout <= y_next;
                end
            end
        end
    end
endmodule
`default_nettype wire
